readback_engine_mc: RTL

//  Parametrised readback path between DRAM read data and the host AXI-Stream
//  (C2H). Two modes: READ (raw words) and DIFF (popcount of rd_data^ref_data,

---
 rtl/readback_engine_mc.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/readback_engine_mc.sv
// ============================================================================
// Module      : readback_engine_mc
// Description : DRAM readback to C2H AXI-Stream. Supports raw READ and DIFF
//               popcount modes, with a word FIFO, width down-conversion,
//               framing, flush terminator and credit accounting.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module readback_engine_mc #(
    parameter int DATA_W = 512,
    parameter int AXIS_W = 256,
    parameter int DEPTH  = 64,
    parameter int PC_W   = 16,
    parameter int IGN_RD = 2,
    parameter int CRED_W = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode_sel,
    input  logic                flush,
    input  logic                per_rd_init,
    input  logic                credit_req,
    input  logic [11:0]         credit_n,
    output logic [CRED_W-1:0]   credit_avail,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                rd_valid,
    input  logic [DATA_W-1:0]   ref_data,
    input  logic [15:0]         xfer_len,
    output logic                overflow,
    output logic [AXIS_W-1:0]   m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic [AXIS_W/8-1:0] m_tkeep
);

    localparam int c_ratio   = DATA_W / AXIS_W;
    localparam int c_lanes   = DATA_W / PC_W;
    localparam int c_slice_w = (c_ratio > 1) ? $clog2(c_ratio) : 1;
    localparam int c_lane_w  = (c_lanes > 1) ? $clog2(c_lanes) : 1;
    localparam int c_ptr_w   = $clog2(DEPTH);
    localparam int c_cnt_w   = $clog2(DATA_W + 1);
    localparam int c_ign_w   = (IGN_RD > 0) ? $clog2(IGN_RD + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WAIT  = 2'd2,
        ST_TERM  = 2'd3
    } flush_state_t;

    flush_state_t                   r_fstate, w_fstate_nxt;
    logic                           r_mode, r_s1_valid, r_s1_mode, r_pc_valid, r_overflow;
    logic [DATA_W-1:0]              r_s1_data;
    logic [c_cnt_w-1:0]             w_pc, r_pc;
    logic [c_lanes-1:0][PC_W-1:0]   r_pack, w_pack_next;
    logic [c_lane_w-1:0]            r_lane;
    logic [c_ign_w-1:0]             r_ign;
    logic [DATA_W-1:0]              r_mem [DEPTH];
    logic [c_ptr_w:0]               r_wr_ptr, r_rd_ptr;
    logic [c_slice_w-1:0]           r_slice;
    logic [15:0]                    r_beat, r_len, w_len, w_len_in;
    logic [CRED_W-1:0]              r_credits;
    logic [DATA_W-1:0]              w_head, w_wr_data;
    logic w_fifo_empty, w_fifo_full, w_accept, w_pipe_empty, w_idle;
    logic w_pack_full, w_flush_part, w_read_wr, w_wr_en, w_term, w_hs, w_hs_data, w_last_slice;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                          (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    // A reload on the same cycle as rd_valid discards that word too
    assign w_accept     = rd_valid && !per_rd_init && (r_ign == '0);
    assign w_pipe_empty = !r_s1_valid && !r_pc_valid;
    assign w_idle       = w_fifo_empty && (r_lane == '0) && w_pipe_empty &&
                          (r_fstate == ST_IDLE) && !w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= 1'b0;
            r_ign      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_data  <= '0;
            r_pc_valid <= 1'b0;
            r_pc       <= '0;
        end else begin
            if (w_idle)
                r_mode <= mode_sel;
            if (per_rd_init)
                r_ign <= c_ign_w'(IGN_RD);
            else if (rd_valid && (r_ign != '0))
                r_ign <= r_ign - c_ign_w'(1);
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_mode <= r_mode;
                r_s1_data <= r_mode ? (rd_data ^ ref_data) : rd_data;
            end
            r_pc_valid <= r_s1_valid && r_s1_mode;
            r_pc       <= w_pc;
        end
    end

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < DATA_W; i++)
            w_pc = w_pc + c_cnt_w'(r_s1_data[i]);
    end

    always_comb begin
        w_pack_next         = r_pack;
        w_pack_next[r_lane] = PC_W'(r_pc);
    end

    assign w_pack_full  = r_pc_valid && (r_lane == c_lane_w'(c_lanes - 1));
    // Unused lanes of a partial word are already zero since the packer clears on write
    assign w_flush_part = (r_fstate == ST_DRAIN) && w_pipe_empty && (r_lane != '0);
    assign w_read_wr    = r_s1_valid && !r_s1_mode;
    assign w_wr_en      = w_read_wr || w_pack_full || w_flush_part;
    assign w_wr_data    = w_read_wr ? r_s1_data : (w_pack_full ? w_pack_next : r_pack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pack <= '0;
            r_lane <= '0;
        end else if (w_pack_full || w_flush_part) begin
            r_pack <= '0;
            r_lane <= '0;
        end else if (r_pc_valid) begin
            r_pack <= w_pack_next;
            r_lane <= r_lane + c_lane_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !w_fifo_full)
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= w_wr_data;
    end

    assign w_term       = (r_fstate == ST_TERM);
    assign w_head       = r_mem[r_rd_ptr[c_ptr_w-1:0]];
    assign w_len_in     = (xfer_len == 16'd0) ? 16'd1 : xfer_len;
    assign w_len        = (r_beat == 16'd0) ? w_len_in : r_len;
    assign w_hs         = m_tvalid && m_tready;
    assign w_hs_data    = w_hs && !w_term;
    assign w_last_slice = (r_slice == c_slice_w'(c_ratio - 1));

    always_comb begin
        m_tvalid = w_term || !w_fifo_empty;
        m_tlast  = w_term || (!w_fifo_empty && (r_beat == w_len - 16'd1));
        m_tdata  = '0;
        if (!w_term && !w_fifo_empty)
            m_tdata = w_head[int'(r_slice)*AXIS_W +: AXIS_W];
    end

    assign m_tkeep      = '1;
    assign overflow     = r_overflow;
    assign credit_avail = r_credits / CRED_W'(c_ratio);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_slice    <= '0;
            r_overflow <= 1'b0;
            r_beat     <= '0;
            r_len      <= 16'd1;
            r_credits  <= CRED_W'(DEPTH * c_ratio);
        end else begin
            if (w_wr_en) begin
                if (w_fifo_full)
                    r_overflow <= 1'b1;
                else
                    r_wr_ptr <= r_wr_ptr + (c_ptr_w+1)'(1);
            end
            if (w_hs_data) begin
                if (w_last_slice) begin
                    r_slice  <= '0;
                    r_rd_ptr <= r_rd_ptr + (c_ptr_w+1)'(1);
                end else begin
                    r_slice <= r_slice + c_slice_w'(1);
                end
            end
            if (w_hs && (r_beat == 16'd0))
                r_len <= w_len_in;
            if (w_hs)
                r_beat <= m_tlast ? 16'd0 : r_beat + 16'd1;
            r_credits <= r_credits
                       - (credit_req ? CRED_W'(credit_n) * CRED_W'(c_ratio) : '0)
                       + CRED_W'(w_hs_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_fstate <= ST_IDLE;
        else
            r_fstate <= w_fstate_nxt;
    end

    always_comb begin
        w_fstate_nxt = r_fstate;
        case (r_fstate)
            ST_IDLE:  if (flush)        w_fstate_nxt = ST_DRAIN;
            ST_DRAIN: if (w_pipe_empty) w_fstate_nxt = ST_WAIT;
            ST_WAIT:  if (w_fifo_empty) w_fstate_nxt = ST_TERM;
            ST_TERM:  if (w_hs)         w_fstate_nxt = ST_IDLE;
            default:                    w_fstate_nxt = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire
